seq_divider: RTL and testbench

Multi-cycle signed 32-bit restoring divider feeding the Z register pair of the datapath bus. It takes the dividend from Y and the divisor from the bus value during the DIV execute step. It returns the quotient for Zlow and the remainder for Zhigh. The control unit starts it with a one-cycle pulse and stalls on busy until done pulses.

---
 rtl/seq_divider.sv | 144 ++++++++++++++
 tb/tb_seq_divider.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider: quotient to Zlow, remainder to Zhigh.
// Outputs are registered one cycle behind the FSM state; results move to the ports with done.
module seq_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             zero_q, zero_d;

   // A stays below M between steps, so only the shifted/subtracted value needs the extra sign bit.
   logic [WIDTH:0]   a_sh;
   logic [WIDTH:0]   a_sub;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= IDLE;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dbz_q   <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dbz_q   <= dbz_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      q_d     = q_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dbz_d   = dbz_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      zero_d  = zero_q;
      busy_d  = (state_q == CALC) || (state_q == FIX);
      done_d  = (state_q == DONE);
      a_sh    = {a_q, q_q[WIDTH-1]};
      a_sub   = a_sh - {1'b0, m_q};

      case (state_q)
         IDLE: begin
            if (start) begin
               qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               rneg_d = dividend[WIDTH-1];
               cnt_d  = '0;
               if (divisor == '0) begin
                  q_d     = '1;
                  a_d     = dividend;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  q_d     = dividend[WIDTH-1] ? -dividend : dividend;
                  m_d     = divisor[WIDTH-1] ? -divisor : divisor;
                  a_d     = '0;
                  dbz_d   = 1'b0;
                  zero_d  = 1'b0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            q_d   = {q_q[WIDTH-2:0], ~a_sub[WIDTH]};
            a_d   = a_sub[WIDTH] ? a_sh[WIDTH-1:0] : a_sub[WIDTH-1:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            q_d     = qneg_q ? -q_q : q_q;
            a_d     = rneg_q ? -a_q : a_q;
            state_d = DONE;
         end
         DONE: begin
            quot_d  = q_q;
            rem_d   = a_q;
            zero_d  = dbz_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised bench for seq_divider; expectations queue up at start and are checked at done.
module tb_seq_divider;

   logic        clock = 1'b0;
   logic        clear;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          lat;
      int          busy_cyc;
   } exp_t;

   exp_t sb[$];

   seq_divider #(.WIDTH(32)) dut (
      .clock       (clock),
      .clear       (clear),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic z);
      if (b == 32'h0) begin
         q = 32'hFFFFFFFF;
         r = a;
         z = 1'b1;
      end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
         q = 32'h80000000;
         r = 32'h0;
         z = 1'b0;
      end else begin
         q = 32'($signed(a) / $signed(b));
         r = 32'($signed(a) % $signed(b));
         z = 1'b0;
      end
   endfunction

   task automatic launch(input logic [31:0] dd, input logic [31:0] dv,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez);
      exp_t e;
      @(negedge clock);
      start    = 1'b1;
      dividend = dd;
      divisor  = dv;
      e.q        = eq;
      e.r        = er;
      e.dbz      = ez;
      e.lat      = ez ? 1 : 34;
      e.busy_cyc = ez ? 0 : 33;
      sb.push_back(e);
      @(posedge clock);
      #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   // inject > 0 pulses a competing start (9/2) that cycle; it must be ignored.
   task automatic wait_done(input int inject);
      int   n      = 0;
      int   busy_n = 0;
      bit   seen   = 1'b0;
      exp_t e;
      while (!seen && n < 100) begin
         @(posedge clock);
         #1;
         n++;
         start = 1'b0;
         if (busy) busy_n++;
         if (done) seen = 1'b1;
         else if (n == inject) begin
            start    = 1'b1;
            dividend = 32'd9;
            divisor  = 32'd2;
         end
      end
      start = 1'b0;
      e = sb.pop_front();
      chk("done_seen", 32'(seen), 32'd1);
      chk("latency", 32'(n), 32'(e.lat));
      chk("busy_cycles", 32'(busy_n), 32'(e.busy_cyc));
      chk("busy_at_done", 32'(busy), 32'd0);
      chk("quotient", quotient, e.q);
      chk("remainder", remainder, e.r);
      chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      @(posedge clock);
      #1;
      chk("done_pulse_width", 32'(done), 32'd0);
   endtask

   task automatic div(input logic [31:0] dd, input logic [31:0] dv,
                      input logic [31:0] eq, input logic [31:0] er, input logic ez,
                      input int inject);
      launch(dd, dv, eq, er, ez);
      wait_done(inject);
   endtask

   task automatic count_done(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clock);
         #1;
         if (done) cnt++;
      end
   endtask

   initial begin
      logic [31:0] ra, rb, rq, rr;
      logic        rz;
      int          extra;

      clear    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_quotient", quotient, 32'h0);
      chk("rst_remainder", remainder, 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clock);
      clear = 1'b0;

      div(32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0, 0);
      repeat (5) @(posedge clock);
      #1;
      chk("hold_quotient", quotient, 32'h0000000E);
      chk("hold_remainder", remainder, 32'h00000002);

      div(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 0);
      div(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002, 1'b0, 0);
      div(32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, 0);
      div(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, 0);
      div(32'h80000000, 32'd1, 32'h80000000, 32'h0, 1'b0, 0);

      div(32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 0);
      repeat (3) @(posedge clock);
      #1;
      chk("hold_dbz", 32'(div_by_zero), 32'd1);
      div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0);

      div(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 10);
      count_done(40, extra);
      chk("no_second_done", 32'(extra), 32'd0);

      @(negedge clock);
      start    = 1'b1;
      dividend = 32'd1000;
      divisor  = 32'd3;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (14) @(posedge clock);
      #3;
      clear = 1'b1;
      #1;
      chk("abort_quotient", quotient, 32'h0);
      chk("abort_remainder", remainder, 32'h0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clock);
      clear = 1'b0;
      count_done(40, extra);
      chk("abort_no_done", 32'(extra), 32'd0);
      div(32'd1000, 32'd3, 32'h0000014D, 32'd1, 1'b0, 0);

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = 32'($urandom_range(1, 5000));
         if (i % 2 == 1) rb = -rb;
         if (i == 5) rb = $urandom;
         model(ra, rb, rq, rr, rz);
         div(ra, rb, rq, rr, rz, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
